sha2_msg_scheduler: RTL and testbench



---
 rtl/sha2_pkg.sv | 32 +++
 rtl/sha2_sigma_sched.sv | 28 ++
 rtl/sha2_msg_scheduler.sv | 146 ++++++++++++++
 tb/tb_sha2_msg_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared state type and build-time helpers for the SHA-2 message scheduler.
// Round count, add latency and sigma rotate amounts all derive from WORD_W / SERIAL_ADD.
package sha2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_COMP
  } sched_state_e;

  function automatic int rounds_f(input int word_w);
    return (word_w == 64) ? 80 : 64;
  endfunction

  function automatic int add_cyc_f(input int serial_add);
    return (serial_add != 0) ? 3 : 1;
  endfunction

  // idx 0..2: sigma0 {rotr, rotr, shr}; idx 3..5: sigma1 {rotr, rotr, shr}
  function automatic int sig_const_f(input int word_w, input int idx);
    case (idx)
      0:       return (word_w == 64) ? 1  : 7;
      1:       return (word_w == 64) ? 8  : 18;
      2:       return (word_w == 64) ? 7  : 3;
      3:       return (word_w == 64) ? 19 : 17;
      4:       return (word_w == 64) ? 61 : 19;
      default: return (word_w == 64) ? 6  : 10;
    endcase
  endfunction

endpackage

// File: rtl/sha2_sigma_sched.sv
// Combinational SHA-2 message-schedule sigma functions.
// o_sigma0 = sigma0(i_x0), o_sigma1 = sigma1(i_x1) for the selected word width.
module sha2_sigma_sched
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_x0,
  input  logic [WORD_W-1:0] i_x1,
  output logic [WORD_W-1:0] o_sigma0,
  output logic [WORD_W-1:0] o_sigma1
);

  localparam int S0_R1 = sig_const_f(WORD_W, 0);
  localparam int S0_R2 = sig_const_f(WORD_W, 1);
  localparam int S0_SH = sig_const_f(WORD_W, 2);
  localparam int S1_R1 = sig_const_f(WORD_W, 3);
  localparam int S1_R2 = sig_const_f(WORD_W, 4);
  localparam int S1_SH = sig_const_f(WORD_W, 5);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  assign o_sigma0 = rotr(i_x0, S0_R1) ^ rotr(i_x0, S0_R2) ^ (i_x0 >> S0_SH);
  assign o_sigma1 = rotr(i_x1, S1_R1) ^ rotr(i_x1, S1_R2) ^ (i_x1 >> S1_SH);

endmodule

// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message-schedule engine: loads M[0..15] into a 16-word circular buffer and
// streams W[0..ROUNDS-1], expanding W[t>=16] in place with a serial or parallel adder.
module sha2_msg_scheduler
  import sha2_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int SERIAL_ADD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  input  logic [WORD_W-1:0] i_word_in,
  output logic              o_wt_valid,
  input  logic              i_wt_ready,
  output logic [WORD_W-1:0] o_wt_data,
  output logic [6:0]        o_wt_index,
  output logic              o_busy,
  output logic              o_done
);

  localparam int         ROUNDS  = rounds_f(WORD_W);
  localparam int         ADD_CYC = add_cyc_f(SERIAL_ADD);
  localparam logic [6:0] LAST_T  = 7'(ROUNDS - 1);
  localparam logic [1:0] LAST_PH = 2'(ADD_CYC - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
  end

  sched_state_e      r_state;
  logic [3:0]        r_cnt;
  logic [6:0]        r_t;
  logic [1:0]        r_ph;
  logic [WORD_W-1:0] r_w;
  logic              r_done;
  logic [WORD_W-1:0] r_mem [16];

  logic [3:0]        w_t4, w_a15, w_a7, w_a2;
  logic [WORD_W-1:0] w_m16, w_m15, w_m7, w_m2;
  logic [WORD_W-1:0] w_s0, w_s1, w_sum;
  logic              w_load_acc, w_comp_last;

  // Taps for W[t-16], W[t-15], W[t-7], W[t-2]; 4-bit wrap gives the mod-16 addressing.
  assign w_t4  = r_t[3:0];
  assign w_a15 = w_t4 + 4'd1;
  assign w_a7  = w_t4 + 4'd9;
  assign w_a2  = w_t4 + 4'd14;
  assign w_m16 = r_mem[w_t4];
  assign w_m15 = r_mem[w_a15];
  assign w_m7  = r_mem[w_a7];
  assign w_m2  = r_mem[w_a2];

  sha2_sigma_sched #(.WORD_W(WORD_W)) u_sigma (
    .i_x0     (w_m15),
    .i_x1     (w_m2),
    .o_sigma0 (w_s0),
    .o_sigma1 (w_s1)
  );

  assign w_load_acc  = (r_state == S_LOAD) && i_word_valid;
  assign w_comp_last = (r_state == S_COMP) && (r_ph == LAST_PH);

  always_comb begin
    // NOTE: assign a default first so no path through this block can infer a latch.
    w_sum = '0;
    if (SERIAL_ADD != 0) begin
      case (r_ph)
        2'd0:    w_sum = w_m16 + w_s0;
        2'd1:    w_sum = r_w + w_m7;
        default: w_sum = r_w + w_s1;
      endcase
    end else begin
      w_sum = w_m16 + w_s0 + w_m7 + w_s1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_t     <= 7'd0;
      r_ph    <= 2'd0;
      r_w     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_state <= S_LOAD;
            r_cnt   <= 4'd0;
            r_t     <= 7'd0;
          end
          S_LOAD: if (i_word_valid) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) r_state <= S_EMIT;
          end
          S_EMIT: if (i_wt_ready) begin
            if (r_t == LAST_T) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_t <= r_t + 7'd1;
              if (r_t >= 7'd15) begin
                r_state <= S_COMP;
                r_ph    <= 2'd0;
              end
            end
          end
          S_COMP: begin
            r_w <= w_sum;
            if (w_comp_last) begin
              r_state <= S_EMIT;
              r_ph    <= 2'd0;
            end else begin
              r_ph <= r_ph + 2'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: the word buffer is deliberately not reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (!i_abort) begin
      if (w_load_acc)       r_mem[r_cnt] <= i_word_in;
      else if (w_comp_last) r_mem[w_t4]  <= w_sum;
    end
  end

  assign o_word_ready = (r_state == S_LOAD);
  assign o_wt_valid   = (r_state == S_EMIT);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_wt_index   = r_t;
  assign o_wt_data    = o_wt_valid ? ((r_t < 7'd16) ? w_m16 : r_w) : '0;

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Self-checking bench: SHA-256 serial and SHA-512 parallel instances, known-answer table
// plus random blocks checked against a full-array software model of the W[t] recurrence.
module tb_sha2_msg_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  start_v;
  logic        abort, word_valid, wt_ready;
  logic [63:0] word_in;

  logic        wr0, wv0, busy0, done0;
  logic [31:0] wd0;
  logic [6:0]  wi0;
  logic        wr1, wv1, busy1, done1;
  logic [63:0] wd1;
  logic [6:0]  wi1;

  sha2_msg_scheduler #(.WORD_W(32), .SERIAL_ADD(1)) u_dut256 (
    .clk(clk), .reset_n(reset_n), .i_start(start_v[0]), .i_abort(abort),
    .i_word_valid(word_valid), .o_word_ready(wr0), .i_word_in(word_in[31:0]),
    .o_wt_valid(wv0), .i_wt_ready(wt_ready), .o_wt_data(wd0), .o_wt_index(wi0),
    .o_busy(busy0), .o_done(done0)
  );

  sha2_msg_scheduler #(.WORD_W(64), .SERIAL_ADD(0)) u_dut512 (
    .clk(clk), .reset_n(reset_n), .i_start(start_v[1]), .i_abort(abort),
    .i_word_valid(word_valid), .o_word_ready(wr1), .i_word_in(word_in),
    .o_wt_valid(wv1), .i_wt_ready(wt_ready), .o_wt_data(wd1), .o_wt_index(wi1),
    .o_busy(busy1), .o_done(done1)
  );

  int          sel;
  logic        o_wr, o_wv, o_busy, o_done;
  logic [63:0] o_wd;
  logic [6:0]  o_wi;

  always_comb begin
    if (sel == 1) begin
      o_wr = wr1; o_wv = wv1; o_busy = busy1; o_done = done1; o_wd = wd1; o_wi = wi1;
    end else begin
      o_wr = wr0; o_wv = wv0; o_busy = busy0; o_done = done0; o_wd = {32'b0, wd0}; o_wi = wi0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          start_cyc, done_lat, last_idx;
  logic [63:0] msg   [16];
  logic [63:0] exp_w [80];
  logic [63:0] cap   [80];
  logic [63:0] cap_abc [2][80];

  typedef struct {
    string       name;
    int          cfg;
    int          t;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n, input int w);
    logic [127:0] d;
    if (w == 32) d = {64'b0, x[31:0], x[31:0]};
    else         d = {x, x};
    d = d >> n;
    return (w == 32) ? {32'b0, d[31:0]} : d[63:0];
  endfunction

  function automatic logic [63:0] sig0_m(input logic [63:0] x, input int w);
    if (w == 32) return rotr_m(x, 7, w) ^ rotr_m(x, 18, w) ^ (x >> 3);
    return rotr_m(x, 1, w) ^ rotr_m(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_m(input logic [63:0] x, input int w);
    if (w == 32) return rotr_m(x, 17, w) ^ rotr_m(x, 19, w) ^ (x >> 10);
    return rotr_m(x, 19, w) ^ rotr_m(x, 61, w) ^ (x >> 6);
  endfunction

  task automatic build_model(input int s);
    int          rounds = (s == 1) ? 80 : 64;
    int          w      = (s == 1) ? 64 : 32;
    logic [63:0] mask   = (s == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t] & mask;
    for (int t = 16; t < rounds; t++)
      exp_w[t] = (sig1_m(exp_w[t-2], w) + exp_w[t-7] + sig0_m(exp_w[t-15], w) + exp_w[t-16]) & mask;
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 16; i++) msg[i] = {32'b0, $urandom()};
  endtask

  // One full block: start, load (optionally gapped / with a spurious start), stream with stalls.
  task automatic run_block(input int s, input int stall_pct, input int gap,
                           input int abort_at, input int restart);
    int          rounds, n, budget, bad_d, bad_i, bad_s;
    logic        stalled;
    logic [63:0] pd;
    logic [6:0]  pi;
    rounds = (s == 1) ? 80 : 64;
    sel = s;
    build_model(s);
    @(negedge clk);
    start_v[s] = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start_v = '0;
    check("start_ready_busy", {o_wr, o_busy}, 2'b11);
    for (int i = 0; i < 16; i++) begin
      word_in    = msg[i];
      word_valid = 1'b1;
      if (restart != 0 && i == 5) start_v[s] = 1'b1;
      @(negedge clk);
      start_v    = '0;
      word_valid = 1'b0;
      if (gap != 0 && i < 15) begin
        word_in = {$urandom(), $urandom()};
        repeat (3) @(negedge clk);
      end
    end
    check("first_valid_idx0", {o_wv, o_wi}, {1'b1, 7'd0});
    n = 0; budget = 4000; bad_d = 0; bad_i = 0; bad_s = 0; stalled = 1'b0;
    pd = '0; pi = '0;
    while (n < rounds && budget > 0) begin
      budget--;
      if (abort_at >= 0 && n == abort_at && !o_wv) begin
        check("in_comp_before_abort", {o_busy, o_wv}, 2'b10);
        wt_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_to_idle", {o_busy, o_wv, o_wr}, 3'b000);
        return;
      end
      if (o_wv) begin
        if (stalled && (o_wd !== pd || o_wi !== pi)) bad_s++;
        wt_ready = ($urandom_range(99) >= stall_pct);
        if (wt_ready) begin
          cap[n] = o_wd;
          if (o_wi !== 7'(n)) bad_i++;
          last_idx = int'(o_wi);
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = o_wd;
          pi = o_wi;
        end
      end else begin
        wt_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
    wt_ready = 1'b0;
    check("word_count", n, rounds);
    check("done_and_idle", {o_done, o_busy}, 2'b10);
    done_lat = cyc - start_cyc;
    for (int t = 0; t < rounds; t++) if (cap[t] !== exp_w[t]) bad_d++;
    check("stream_vs_model", bad_d, 0);
    check("index_sequence", bad_i, 0);
    check("stall_stable", bad_s, 0);
  endtask

  initial begin
    vecs[0] = '{"abc256_W16", 0, 16, 64'h0000_0000_6162_6380};
    vecs[1] = '{"abc256_W17", 0, 17, 64'h0000_0000_000F_0000};
    vecs[2] = '{"abc256_W18", 0, 18, 64'h0000_0000_7DA8_6405};
    vecs[3] = '{"abc512_W16", 1, 16, 64'h6162_6380_0000_0000};
    vecs[4] = '{"abc512_W17", 1, 17, 64'h0003_0000_0000_00C0};

    start_v = '0; abort = 1'b0; word_valid = 1'b0; wt_ready = 1'b0; word_in = '0; sel = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset_ctrl", {o_wr, o_wv, o_busy, o_done}, 4'b0000);
      check("reset_data", o_wd, 0);
      check("reset_index", o_wi, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 64'h6162_6380; msg[15] = 64'h18;
    run_block(0, 0, 0, -1, 0);
    check("latency_256_serial", done_lat, 1 + 16 + 16 + 48 * 4);
    for (int t = 0; t < 64; t++) cap_abc[0][t] = cap[t];
    @(negedge clk);
    check("done_one_cycle", o_done, 0);

    msg[0] = 64'h6162_6380_0000_0000; msg[15] = 64'h18;
    run_block(1, 0, 0, -1, 0);
    check("latency_512_parallel", done_lat, 1 + 16 + 16 + 64 * 2);
    check("last_index_79", last_idx, 79);
    for (int t = 0; t < 80; t++) cap_abc[1][t] = cap[t];

    for (int v = 0; v < 5; v++) check(vecs[v].name, cap_abc[vecs[v].cfg][vecs[v].t], vecs[v].exp);

    for (int b = 0; b < 20; b++) begin
      rand_msg();
      run_block(0, 50, 0, -1, 0);
    end

    rand_msg();
    run_block(0, 0, 1, -1, 0);

    rand_msg();
    run_block(0, 0, 0, 40, 0);
    rand_msg();
    run_block(0, 0, 0, -1, 1);

    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    for (int i = 0; i < 5; i++) begin
      word_in = {32'b0, $urandom()};
      word_valid = 1'b1;
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_ctrl", {o_wr, o_wv, o_busy, o_done}, 4'b0000);
    check("async_reset_index", o_wi, 0);
    word_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rand_msg();
    run_block(0, 0, 0, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
